// File: rtl/aes_byte_host.sv
// Byte-serial host for an AES engine: loads cmd/key/data frames, runs the engine, streams result.
// Optional engine watchdog enabled by defining AES_HOST_TIMEOUT_EN.
module aes_byte_host #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         s_valid,
  input  logic [7:0]   s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [7:0]   m_data,
  input  logic         m_ready,
  output logic [127:0] aes_key,
  output logic [127:0] aes_data_in,
  output logic         aes_enable,
  output logic         aes_ed,
  output logic         aes_reset,
  input  logic         aes_done,
  input  logic [127:0] aes_data_out,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadKey,
    StLoadData,
    StStart,
    StRun,
`ifdef AES_HOST_TIMEOUT_EN
    StSend,
    StError
`else
    StSend
`endif
  } state_e;

  state_e         state;
  logic [3:0]     byte_cnt;
  logic [127:0]   result_q;
  logic           done_q;
`ifdef AES_HOST_TIMEOUT_EN
  logic [31:0]    tmo_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  assign s_ready = (state == StIdle) || (state == StLoadKey) || (state == StLoadData);
  assign busy    = (state != StIdle);
  assign m_valid = (state == StSend);
  // Result shifts left as bytes leave, so the current byte is always the top one.
  assign m_data  = result_q[127:120];

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= StIdle;
      byte_cnt    <= 4'd0;
      result_q    <= '0;
      done_q      <= 1'b0;
      aes_key     <= '0;
      aes_data_in <= '0;
      aes_enable  <= 1'b0;
      aes_ed      <= 1'b0;
      aes_reset   <= 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done_q <= aes_done;
      unique case (state)
        StIdle: begin
          if (s_valid) begin
            aes_ed   <= s_data[0];
            byte_cnt <= 4'd0;
            state    <= StLoadKey;
`ifdef AES_HOST_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        StLoadKey: begin
          if (s_valid) begin
            aes_key  <= {aes_key[119:0], s_data};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) state <= StLoadData;
          end
        end
        StLoadData: begin
          if (s_valid) begin
            aes_data_in <= {aes_data_in[119:0], s_data};
            byte_cnt    <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              state     <= StStart;
              aes_reset <= 1'b1;
            end
          end
        end
        StStart: begin
          aes_reset  <= 1'b0;
          aes_enable <= 1'b1;
          state      <= StRun;
`ifdef AES_HOST_TIMEOUT_EN
          tmo_cnt    <= '0;
`endif
        end
        StRun: begin
          // Only a rising edge counts; a sticky done left over from before RUN is ignored.
          if (aes_done && !done_q) begin
            result_q   <= aes_data_out;
            aes_enable <= 1'b0;
            byte_cnt   <= 4'd0;
            state      <= StSend;
          end
`ifdef AES_HOST_TIMEOUT_EN
          else if (tmo_cnt == TIMEOUT_CYCLES - 1) begin
            aes_enable  <= 1'b0;
            aes_reset   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= StError;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
`endif
        end
        StSend: begin
          if (m_ready) begin
            result_q <= {result_q[119:0], 8'h00};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) state <= StIdle;
          end
        end
`ifdef AES_HOST_TIMEOUT_EN
        StError: begin
          aes_reset <= 1'b0;
          state     <= StIdle;
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_host.sv
// Directed bench for aes_byte_host with a behavioural engine returning FIPS-197 vectors.
module tb_aes_byte_host;

  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_HOST_TIMEOUT_EN
  localparam int unsigned TMO     = 16;
  localparam int unsigned ENG_LAT = 10;
`else
  localparam int unsigned TMO     = 4096;
  localparam int unsigned ENG_LAT = 20;
`endif

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         s_ready;
  logic         m_valid;
  logic [7:0]   m_data;
  logic         m_ready = 1'b0;
  logic [127:0] aes_key;
  logic [127:0] aes_data_in;
  logic         aes_enable;
  logic         aes_ed;
  logic         aes_reset;
  logic         aes_done;
  logic [127:0] aes_data_out;
  logic         busy;
  logic         timeout_err;

  int n_checks = 0;
  int n_bad = 0;

  logic         hold_done = 1'b0;
  logic         eng_done;
  logic [127:0] eng_out;
  int unsigned  eng_cnt;

  always #5 clock = ~clock;

  aes_byte_host #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .aes_key(aes_key), .aes_data_in(aes_data_in), .aes_enable(aes_enable),
    .aes_ed(aes_ed), .aes_reset(aes_reset), .aes_done(aes_done),
    .aes_data_out(aes_data_out), .busy(busy), .timeout_err(timeout_err)
  );

  // Engine model: sticky done ENG_LAT enabled cycles after start, cleared by aes_reset.
  assign aes_done     = eng_done | hold_done;
  assign aes_data_out = eng_out;

  always @(posedge clock) begin
    if (rst || aes_reset) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
      eng_out  <= '0;
    end else if (aes_enable && !eng_done) begin
      if (eng_cnt == ENG_LAT - 1) begin
        eng_done <= 1'b1;
        if (aes_ed) eng_out <= (aes_key == K && aes_data_in == PT) ? CT : ~aes_data_in;
        else        eng_out <= (aes_key == K && aes_data_in == CT) ? PT : ~aes_data_in;
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g = 0;
    repeat ($urandom_range(0, maxgap)) begin
      @(negedge clock);
      s_valid = 1'b0;
    end
    @(negedge clock);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (g >= 100) check("s_ready_wait", 1'b0, 1'b1);
    @(posedge clock);
    #1;
  endtask

  task automatic send_body(input logic [127:0] key, input logic [127:0] data, input int maxgap);
    for (int i = 0; i < 16; i++) send_byte(key[8*(15-i) +: 8], maxgap);
    for (int i = 0; i < 16; i++) send_byte(data[8*(15-i) +: 8], maxgap);
  endtask

  // Called #1 after the final data byte edge: START now, RUN on the next edge.
  task automatic check_start(input logic ed, input logic [127:0] key, input logic [127:0] data);
    s_valid = 1'b0;
    check("start_reset", aes_reset, 1'b1);
    check("start_enable", aes_enable, 1'b0);
    check("start_sready", s_ready, 1'b0);
    @(posedge clock);
    #1;
    check("run_reset", aes_reset, 1'b0);
    check("run_enable", aes_enable, 1'b1);
    check("run_ed", aes_ed, ed);
    check("run_key", aes_key, key);
    check("run_data", aes_data_in, data);
  endtask

  task automatic recv_block(input logic toggle, output logic [127:0] got);
    int n = 0;
    int guard = 0;
    logic held = 1'b0;
    logic [7:0] prev = 8'h00;
    got = '0;
    while (n < 16 && guard < 3000) begin
      @(negedge clock);
      guard++;
      if (held && m_valid) check("send_stable", m_data, prev);
      held = 1'b0;
      m_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid) begin
        if (m_ready) begin
          got = {got[119:0], m_data};
          n++;
        end else begin
          held = 1'b1;
          prev = m_data;
        end
      end
    end
    check("recv_count", n, 16);
    @(negedge clock);
    m_ready = 1'b0;
    check("post_send_busy", busy, 1'b0);
    check("post_send_mvalid", m_valid, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [127:0] data, input int maxgap,
                           input logic toggle, input logic [127:0] exp, input string tag);
    logic [127:0] got;
    send_byte(cmd, maxgap);
    send_body(K, data, maxgap);
    check_start(cmd[0], K, data);
    recv_block(toggle, got);
    check(tag, got, exp);
  endtask

  initial begin
    logic [127:0] got;
    int seen;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_sready", s_ready, 1'b1);
    check("rst_mvalid", m_valid, 1'b0);
    check("rst_enable", aes_enable, 1'b0);
    check("rst_aesreset", aes_reset, 1'b0);
    check("rst_key", aes_key, 128'h0);
    check("rst_tmo", timeout_err, 1'b0);
    @(negedge clock);
    rst = 1'b0;

    run_frame(8'h01, PT, 0, 1'b0, CT, "enc_result");
    run_frame(8'hfe, CT, 3, 1'b1, PT, "dec_result");
    run_frame(8'h81, PT, 3, 1'b1, CT, "enc_gap_result");

    // Reset after 10 key bytes drops the partial frame.
    send_byte(8'h01, 0);
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1);
    @(negedge clock);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_sready", s_ready, 1'b1);
    check("midrst_key", aes_key, 128'h0);
    @(negedge clock);
    rst = 1'b0;
    run_frame(8'h01, PT, 1, 1'b0, CT, "after_rst_result");

    // aes_done already high on RUN entry must not count as completion.
    hold_done = 1'b1;
    seen = 0;
    send_byte(8'h01, 0);
    send_body(K, PT, 0);
    s_valid = 1'b0;
    @(posedge clock);
    #1;
    check("hold_run_enable", aes_enable, 1'b1);
`ifdef AES_HOST_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      @(posedge clock);
      #1;
      if (m_valid) seen++;
    end
    check("tmo_early", timeout_err, 1'b0);
    @(posedge clock);
    #1;
    check("tmo_set", timeout_err, 1'b1);
    check("tmo_aesreset", aes_reset, 1'b1);
    check("tmo_enable", aes_enable, 1'b0);
    @(posedge clock);
    #1;
    check("tmo_idle_busy", busy, 1'b0);
    check("tmo_pulse_end", aes_reset, 1'b0);
    check("tmo_sticky", timeout_err, 1'b1);
    check("tmo_no_mvalid", seen + int'(m_valid), 0);
    hold_done = 1'b0;
    send_byte(8'h01, 0);
    check("tmo_cleared", timeout_err, 1'b0);
    send_body(K, PT, 0);
    check_start(1'b1, K, PT);
    recv_block(1'b1, got);
    check("tmo_next_result", got, CT);
`else
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      if (m_valid || !busy) seen++;
    end
    check("hold_no_complete", seen, 0);
    check("hold_still_enable", aes_enable, 1'b1);
    @(negedge clock);
    rst = 1'b1;
    hold_done = 1'b0;
    @(posedge clock);
    #1;
    check("runrst_busy", busy, 1'b0);
    check("runrst_enable", aes_enable, 1'b0);
    @(negedge clock);
    rst = 1'b0;
    run_frame(8'h00, CT, 2, 1'b1, PT, "after_runrst_result");
`endif
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
